// File: rtl/logic_func_engine.sv
// Clocked evaluator of pair-OR-AND, low-pair AND and parity over a WIDTH-bit operand,
// with a registered valid/ready output and a self-driven exhaustive sweep that tallies results.
module logic_func_engine #(
  parameter int WIDTH = 4,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             start,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_r1,
  output logic             out_r2,
  output logic             out_r3,
  output logic             busy,
  output logic             sweep_done,
  output logic [CNT_W-1:0] cnt_r1,
  output logic [CNT_W-1:0] cnt_r2,
  output logic [CNT_W-1:0] cnt_r3,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [WIDTH:0]   LAST    = {1'b0, {WIDTH{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [WIDTH:0]   gen;
  logic             alive;
  logic             load_ok;
  logic             hs;
  logic             start_acc;
  logic             ext_fire;
  logic             sweep_load;
  logic             next_valid;
  logic [WIDTH-1:0] next_data;

  function automatic logic f_r1(input logic [WIDTH-1:0] d);
    logic odd_any;
    logic even_any;
    odd_any  = 1'b0;
    even_any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i % 2) == 1) odd_any  = odd_any | d[i];
      else              even_any = even_any | d[i];
    end
    return odd_any & even_any;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
  endfunction

  // Valid/ready: a transfer happens on a rising clk edge where valid & ready are both high;
  // the producer holds valid and payload stable until then, ready never depends on a pending transfer.
  always_comb begin
    load_ok    = !out_valid | out_ready;
    hs         = out_valid & out_ready;
    start_acc  = (state == IDLE) & start & mode;
    in_ready   = alive & (state == IDLE) & load_ok;
    ext_fire   = in_valid & in_ready;
    sweep_load = (state == SWEEP) & load_ok;
    next_valid = ext_fire | sweep_load;
    next_data  = sweep_load ? gen[WIDTH-1:0] : in_data;
    busy       = (state != IDLE);
    sweep_done = (state == DRAIN) & hs;
    dbg_state  = state;
  end

  // alive keeps in_ready low through reset and for the edge that ends it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
      state <= IDLE;
      gen   <= '0;
    end else begin
      alive <= 1'b1;
      case (state)
        IDLE: begin
          if (start_acc) begin
            state <= SWEEP;
            gen   <= '0;
          end
        end
        SWEEP: begin
          if (load_ok) begin
            gen <= gen + (WIDTH+1)'(1);
            if (gen == LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_r1    <= 1'b0;
      out_r2    <= 1'b0;
      out_r3    <= 1'b0;
    end else if (load_ok) begin
      out_valid <= next_valid;
      if (next_valid) begin
        out_data <= next_data;
        out_r1   <= f_r1(next_data);
        out_r2   <= next_data[1] & next_data[0];
        out_r3   <= ^next_data;
      end
    end
  end

  // Clear (external or from an accepted start) wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r1 <= '0;
      cnt_r2 <= '0;
      cnt_r3 <= '0;
    end else if (clr || start_acc) begin
      cnt_r1 <= '0;
      cnt_r2 <= '0;
      cnt_r3 <= '0;
    end else if (hs) begin
      cnt_r1 <= sat_inc(cnt_r1, out_r1);
      cnt_r2 <= sat_inc(cnt_r2, out_r2);
      cnt_r3 <= sat_inc(cnt_r3, out_r3);
    end
  end

endmodule
